// File: rtl/arm_multicycle_ctrl_if.sv
// Handshake/control bundle between the multicycle controller and its datapath.
// slave  = controller side (consumes instruction/flags/ready, drives controls).
// master = datapath side.
interface arm_multicycle_ctrl_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemW;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [3:0]  Flags;
  logic [3:0]  state_o;

  modport slave (
    input  Instr, ALUFlags, mem_ready,
    output PCWrite, AdrSrc, MemW, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, state_o
  );

  modport master (
    output Instr, ALUFlags, mem_ready,
    input  PCWrite, AdrSrc, MemW, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, state_o
  );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM-subset controller: one FSM state per cycle, NZCV register,
// condition evaluation, and memory-ready stretching of FETCH/MEMRD/MEMWR.
module arm_multicycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit NEVER_ON_1111 = 1'b1
) (
  input logic clk,
  input logic reset,
  arm_multicycle_ctrl_if.slave bus
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  logic [3:0] r_state, w_next;
  logic [3:0] r_flags;

  logic [3:0] w_cond, w_cmd, w_rd;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic       w_ready, w_condex, w_nowrite, w_cv_upd;
  logic [1:0] w_aluop;
  logic       w_pcw, w_memw, w_irw, w_regw;
  logic       w_n, w_z, w_c, w_v;

  assign w_cond  = bus.Instr[31:28];
  assign w_op    = bus.Instr[27:26];
  assign w_funct = bus.Instr[25:20];
  assign w_rd    = bus.Instr[15:12];
  assign w_cmd   = w_funct[4:1];
  assign w_ready = USE_MEM_READY ? bus.mem_ready : 1'b1;
  assign {w_n, w_z, w_c, w_v} = r_flags;

  logic w_unused;
  assign w_unused = ^{bus.Instr[19:16], bus.Instr[11:0]};

  // condition-field evaluation against the registered flags
  always_comb begin
    w_condex = 1'b0;
    case (w_cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = (w_n == w_v);
      4'b1011: w_condex = (w_n != w_v);
      4'b1100: w_condex = ~w_z & (w_n == w_v);
      4'b1101: w_condex = w_z | (w_n != w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = ~NEVER_ON_1111;
    endcase
  end

  // data-processing cmd decode; unsupported cmds add but never write back
  always_comb begin
    w_aluop   = 2'b00;
    w_nowrite = 1'b0;
    w_cv_upd  = 1'b0;
    case (w_cmd)
      4'b0100: begin w_aluop = 2'b00; w_cv_upd = 1'b1; end
      4'b0010: begin w_aluop = 2'b01; w_cv_upd = 1'b1; end
      4'b0000: w_aluop = 2'b10;
      4'b1100: w_aluop = 2'b11;
      4'b1010: begin w_aluop = 2'b01; w_nowrite = 1'b1; w_cv_upd = 1'b1; end
      default: begin w_aluop = 2'b00; w_nowrite = 1'b1; end
    endcase
  end

  // next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: case (w_op)
                  2'b00:   w_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                  2'b01:   w_next = S_MEMADR;
                  2'b10:   w_next = S_BRANCH;
                  default: w_next = S_FETCH;
                endcase
      S_MEMADR:   w_next = w_funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    w_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXECUTER,
      S_EXECUTEI: w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // per-state datapath controls; anything not named for a state stays 0
  always_comb begin
    w_pcw = 1'b0; w_memw = 1'b0; w_irw = 1'b0; w_regw = 1'b0;
    bus.AdrSrc = 1'b0; bus.ResultSrc = 2'b00; bus.ALUSrcA = 1'b0;
    bus.ALUSrcB = 2'b00; bus.ALUControl = 2'b00;
    case (r_state)
      S_FETCH: begin
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
        w_irw = w_ready; w_pcw = w_ready;
      end
      S_DECODE: begin
        bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
      end
      S_MEMADR:   bus.ALUSrcB = 2'b01;
      S_MEMRD:    bus.AdrSrc = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc = 2'b01; w_regw = w_condex;
      end
      S_MEMWR: begin
        bus.AdrSrc = 1'b1; w_memw = w_condex;
      end
      S_EXECUTER: bus.ALUControl = w_aluop;
      S_EXECUTEI: begin
        bus.ALUSrcB = 2'b01; bus.ALUControl = w_aluop;
      end
      S_ALUWB: begin
        w_regw = w_condex & ~w_nowrite;
        w_pcw  = w_condex & ~w_nowrite & (w_rd == 4'd15);
      end
      S_BRANCH: begin
        bus.ALUSrcB = 2'b01; bus.ResultSrc = 2'b10; w_pcw = w_condex;
      end
      default: ;
    endcase
  end

  // write enables are held off for as long as reset is low
  assign bus.PCWrite  = w_pcw  & reset;
  assign bus.MemW     = w_memw & reset;
  assign bus.IRWrite  = w_irw  & reset;
  assign bus.RegWrite = w_regw & reset;
  assign bus.ImmSrc   = w_op;
  assign bus.RegSrc   = {w_op == 2'b01, w_op == 2'b10};
  assign bus.Flags    = r_flags;
  assign bus.state_o  = r_state;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // NZCV register, written only in the execute cycle of a flag-setting op
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if ((r_state == S_EXECUTER || r_state == S_EXECUTEI) && w_condex &&
                 (w_funct[0] || w_cmd == 4'b1010)) begin
      r_flags[3:2] <= bus.ALUFlags[3:2];
      if (w_cv_upd) r_flags[1:0] <= bus.ALUFlags[1:0];
    end
  end
endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
- Control FSM that sequences a multicycle ARM-subset datapath: the register file, extender, SrcA/SrcB muxes, ALU and a shared instruction/data memory.
- Decodes the latched instruction and holds the NZCV flag register.
- Evaluates the condition field and drives all mux selects and write enables, one state per cycle.
- Stretches memory states on a memory-ready handshake.

Parameters:
- USE_MEM_READY, 1, when 1 the FETCH, MEMRD and MEMWR states wait for mem_ready; when 0 mem_ready is treated as constant 1.
- NEVER_ON_1111, 1, when 1 cond=4'b1111 never executes; when 0 it executes as AL.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- Instr  input  32  latched instruction; uses cond=[31:28], op=[27:26], funct=[25:20], Rd=[15:12].
- ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
- mem_ready  input  1  memory accepted the write or has the read data this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
- MemW  output  1  memory write enable.
- IRWrite  output  1  instruction register enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  output  1  SrcA select: 0=RD1, 1=PC.
- ALUSrcB  output  2  SrcB select: 00=RD2, 01=ExtImm, 10=const 4.
- ALUControl  output  2  ALU op: 00=ADD, 01=SUB, 10=AND, 11=ORR.
- ImmSrc  output  2  extender mode; equals op.
- RegSrc  output  2  register-address selects; bit0=(op==10), bit1=(op==01).
- Flags  output  4  current NZCV register.
- state_o  output  4  current state, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10–15 go to FETCH on the next edge.
- Reset (reset=0 at a rising edge):
  - state <= FETCH, Flags <= 4'b0000.
  - While reset=0, PCWrite, MemW, IRWrite and RegWrite are forced to 0 combinationally.
  - Reset wins over every other event, including mid-instruction and during a memory wait.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - mem_ready=1: IRWrite=1, PCWrite=1 (unconditional), go to DECODE.
  - mem_ready=0: both enables 0, stay in FETCH.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (forms PC+8 for R15 reads). Next state by op:
  - op=00, funct[5]=1 → EXECUTEI.
  - op=00, funct[5]=0 → EXECUTER.
  - op=01 → MEMADR.
  - op=10 → BRANCH.
  - op=11 → FETCH (treated as NOP).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. funct[0]=1 → MEMRD, else → MEMWR.
- MEMRD: AdrSrc=1. Hold until mem_ready=1, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx, → FETCH.
- MEMWR: AdrSrc=1, MemW=CondEx. MemW stays asserted until mem_ready=1, then → FETCH.
- EXECUTER / EXECUTEI: ALUSrcA=0, ALUSrcB=00 (EXECUTER) or 01 (EXECUTEI). ALUControl is decoded from cmd=funct[4:1]:
  - 0100 → ADD; 0010 → SUB; 0000 → AND; 1100 → ORR.
  - 1010 (CMP) → SUB with NoWrite=1.
  - any other cmd → ADD with NoWrite=1.
  - Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondEx & ~NoWrite, PCWrite=CondEx & ~NoWrite & (Rd==15). → FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx. → FETCH.
- Flag update, in the EXECUTER/EXECUTEI cycle only:
  - If CondEx & (funct[0] | cmd==1010): NZ <= ALUFlags[3:2].
  - CV <= ALUFlags[1:0] only when cmd ∈ {ADD, SUB, CMP}.
  - Updated flags are first visible to the next instruction.
- CondEx is combinational from cond and the registered Flags:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1.
  - 1111 per NEVER_ON_1111.
- Every output not listed for a state is 0.

Test Plan:
- Reset held low for 3 cycles while mem_ready=1 → state_o=0, all enables 0, Flags=0. First edge after release asserts IRWrite and PCWrite.
- Instr=0xE2821005 (ADD R2+#5), mem_ready=1 → states 0,1,7,8. ALUWB: RegWrite=1, ResultSrc=00, PCWrite=0. Flags unchanged.
- Instr=0xE5910004 (LDR) with mem_ready=0 for 2 cycles in MEMRD → states 0,1,2,3,3,3,4. RegWrite=1 only in MEMWB with ResultSrc=01.
- Instr=0xE5810004 (STR) → states 0,1,2,5 with AdrSrc=1 and MemW=1. Drop mem_ready for 1 cycle → MemW held for 2 cycles, then FETCH.
- CMP: Instr=0xE3510000 with ALUFlags=0100 → Flags=0100, RegWrite=0 in ALUWB. Then Instr=0x0A000002 (BEQ) → BRANCH with PCWrite=1. Repeat with ALUFlags=0000 → PCWrite=0 in BRANCH.
- Instr=0xE080F002 (ADD Rd=15) → PCWrite=1 and RegWrite=1 in ALUWB. Same instruction with cond=1111 → both 0.
